// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch sequencer: widths, opcode values,
// status flag positions and the fetch state encoding.
package isa_pkg;

   localparam int ISA_OP_W = 7;
   localparam int ISA_K_W  = 8;

   localparam logic [ISA_OP_W-1:0] OP_NOP  = 7'h7E;
   localparam logic [ISA_OP_W-1:0] OP_HALT = 7'h7F;
   localparam logic [ISA_OP_W-1:0] OP_JMP  = 7'h50;
   localparam logic [ISA_OP_W-1:0] OP_JEQ  = 7'h51;
   localparam logic [ISA_OP_W-1:0] OP_JNE  = 7'h52;
   localparam logic [ISA_OP_W-1:0] OP_JGT  = 7'h53;
   localparam logic [ISA_OP_W-1:0] OP_JLT  = 7'h54;
   localparam logic [ISA_OP_W-1:0] OP_JGE  = 7'h55;
   localparam logic [ISA_OP_W-1:0] OP_JLE  = 7'h56;
   localparam logic [ISA_OP_W-1:0] OP_JCS  = 7'h57;
   localparam logic [ISA_OP_W-1:0] OP_CALL = 7'h58;
   localparam logic [ISA_OP_W-1:0] OP_RET  = 7'h59;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_REQ,
      FS_EXEC,
      FS_HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory req/ack bus between the fetch sequencer (master) and
// the instruction memory (slave).
interface fetch_sequencer_if #(
   parameter int PC_W = 8,
   parameter int OP_W = 7,
   parameter int K_W  = 8
);
   logic                 imem_req;
   logic [PC_W-1:0]      imem_addr;
   logic                 imem_ack;
   logic [OP_W+K_W-1:0]  imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_sequencer_branch_eval.sv
// Combinational flow-control decode: flags jump-class opcodes and whether they
// are taken. CALL/RET are flow control only when FETCH_SEQ_CALL_EN is defined.
module branch_eval
   import isa_pkg::*;
(
   input  logic [ISA_OP_W-1:0] op,
   input  logic [3:0]          status,
   output logic                is_flow,
   output logic                taken
);

   logic z;
   logic n;
   logic c;
   logic unused_flags;

   assign z = status[FLAG_Z];
   assign n = status[FLAG_N];
   assign c = status[FLAG_C];
   // No jump condition looks at overflow.
   assign unused_flags = status[FLAG_V];

   always_comb begin
      is_flow = 1'b1;
      taken   = 1'b0;
      case (op)
         OP_JMP: taken = 1'b1;
         OP_JEQ: taken = z;
         OP_JNE: taken = !z;
         OP_JGT: taken = !n && !z;
         OP_JLT: taken = n;
         OP_JGE: taken = !n;
         OP_JLE: taken = n || z;
         OP_JCS: taken = c;
`ifdef FETCH_SEQ_CALL_EN
         OP_CALL,
         OP_RET: taken = 1'b1;
`endif
         default: is_flow = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing: fetches over req/ack, resolves jumps locally and
// presents ALU/MOV opcodes to the decoder. FETCH_SEQ_CALL_EN adds CALL/RET.
module fetch_sequencer
   import isa_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int OP_W = ISA_OP_W,
   parameter int K_W  = ISA_K_W
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_sequencer_if.master   imem,
   input  logic [3:0]          status,
   output logic [OP_W-1:0]     opcode,
   output logic [K_W-1:0]      literal,
   output logic                issue,
   output logic                branch_taken,
   output logic                halted,
   output logic [PC_W-1:0]     pc
);

   fetch_state_t          state_reg;
   logic [PC_W-1:0]       pc_reg;
   logic [PC_W-1:0]       pc_inc;
   logic [PC_W-1:0]       pc_next;
   logic [OP_W+K_W-1:0]   ir_reg;
   logic                  req_reg;
   logic [OP_W-1:0]       ir_op;
   logic [K_W-1:0]        ir_k;
   logic                  in_exec;
   logic                  is_halt;
   logic                  is_flow;
   logic                  taken;
`ifdef FETCH_SEQ_CALL_EN
   logic [PC_W-1:0]       ret_reg;
`endif

   assign ir_op   = ir_reg[OP_W+K_W-1:K_W];
   assign ir_k    = ir_reg[K_W-1:0];
   assign in_exec = (state_reg == FS_EXEC);
   assign is_halt = (ir_op == OP_HALT);
   assign pc_inc  = pc_reg + 1'b1;

   branch_eval u_branch_eval (
      .op      (ir_op),
      .status  (status),
      .is_flow (is_flow),
      .taken   (taken)
   );

   always_comb begin
      pc_next = pc_inc;
      if (taken) begin
         pc_next = ir_k[PC_W-1:0];
`ifdef FETCH_SEQ_CALL_EN
         if (ir_op == OP_RET) begin
            pc_next = ret_reg;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= FS_IDLE;
         pc_reg    <= '0;
         ir_reg    <= {OP_NOP, {K_W{1'b0}}};
         req_reg   <= 1'b0;
`ifdef FETCH_SEQ_CALL_EN
         ret_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            FS_IDLE: begin
               state_reg <= FS_REQ;
               req_reg   <= 1'b1;
            end
            FS_REQ: begin
               if (imem.imem_ack) begin
                  ir_reg    <= imem.imem_rdata;
                  req_reg   <= 1'b0;
                  state_reg <= FS_EXEC;
               end
            end
            FS_EXEC: begin
               // pc is left pointing at the HALT word so it stays observable.
               if (is_halt) begin
                  state_reg <= FS_HALT;
               end else begin
                  pc_reg    <= pc_next;
                  req_reg   <= 1'b1;
                  state_reg <= FS_REQ;
`ifdef FETCH_SEQ_CALL_EN
                  if (ir_op == OP_CALL) begin
                     ret_reg <= pc_inc;
                  end
`endif
               end
            end
            default: state_reg <= FS_HALT;
         endcase
      end
   end

   // Decoder-facing outputs are decoded from ir and state only; they are
   // meaningful for exactly the EXEC cycle.
   always_comb begin
      opcode       = OP_NOP;
      literal      = '0;
      issue        = 1'b0;
      branch_taken = 1'b0;
      if (in_exec) begin
         literal      = ir_k;
         branch_taken = taken;
         if (!is_flow && !is_halt) begin
            opcode = ir_op;
            issue  = 1'b1;
         end
      end
   end

   assign halted         = (state_reg == FS_HALT);
   assign pc             = pc_reg;
   assign imem.imem_req  = req_reg;
   assign imem.imem_addr = pc_reg;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing block. It drives the opcode and literal that the control decoder consumes. It holds the program counter and fetches 15-bit instruction words ({opcode[6:0], K[7:0]}) from instruction memory over a req/ack handshake. It presents one instruction per execute cycle and resolves jumps itself from the datapath status flags. The decoder then sees only ALU/MOV opcodes, or NOP.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- OP_W, 7, opcode width
- K_W, 8, literal width; jump targets are K[PC_W-1:0]

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address, equals pc while imem_req=1
- imem_ack  in  1  read data valid this cycle; ignored when imem_req=0
- imem_rdata  in  OP_W+K_W  instruction word, sampled on ack cycle
- status  in  4  datapath flags: [0]=Z, [1]=N, [2]=C, [3]=V
- opcode  out  OP_W  to control decoder; NOP (7'h7E) outside EXEC
- literal  out  K_W  K field of current instruction
- issue  out  1  1-cycle strobe; datapath commits the presented opcode
- branch_taken  out  1  1-cycle strobe on taken jump
- halted  out  1  high in HALT state
- pc  out  PC_W  current program counter

## Operation
- States:
  - IDLE: one cycle after reset, then goes to REQ.
  - REQ: imem_req=1. On imem_ack, capture imem_rdata into the instruction register (ir) and go to EXEC.
  - EXEC: decode ir, update pc, then go to REQ, or to HALT on the HALT opcode.
  - HALT: terminal; exit only by reset.
- Flow-control opcodes (K = target):
  - JMP 7'h50: always taken
  - JEQ 7'h51: Z
  - JNE 7'h52: !Z
  - JGT 7'h53: !N&!Z
  - JLT 7'h54: N
  - JGE 7'h55: !N
  - JLE 7'h56: N|Z
  - JCS 7'h57: C
  - HALT 7'h7F
- In EXEC with a flow-control opcode: opcode output is NOP, issue=0.
  - Taken: pc<=K[PC_W-1:0], branch_taken=1.
  - Not taken: pc<=pc+1.
- In EXEC with any other opcode: opcode=ir opcode, literal=ir K, issue=1, pc<=pc+1. Unknown opcodes pass through; the decoder treats them as no-ops.
- pc+1 wraps modulo 2^PC_W (pc=8'hFF -> 8'h00). No overflow flag.
- status is sampled during EXEC of the jump. It reflects the last committed ALU instruction, because the previous EXEC finished at least one REQ cycle earlier.
- imem_addr is stable for the whole REQ state. An ack arriving in the same cycle req is first asserted is accepted.

## Timing
- Reset values: imem_req=0, imem_addr=0, pc=0, opcode=7'h7E, literal=0, issue=0, branch_taken=0, halted=0, ir=NOP.
- First request is asserted in cycle 2 after rst_n rises: IDLE takes one cycle.
- Minimum 2 cycles per instruction: REQ with same-cycle ack, then EXEC. An N-cycle ack wait adds N cycles.
- opcode, literal, issue and branch_taken are driven from ir and state (registered source). They are valid for exactly the EXEC cycle.
- Reset mid-fetch: on the next edge with rst_n=0, imem_req drops and any late ack is ignored. The state returns to IDLE.
- Reset during EXEC: pc and ret_reg do not update and issue is not seen as committed.

## Configuration
- FETCH_SEQ_CALL_EN defined:
  - Adds a 1-deep return register ret_reg (reset 0).
  - CALL 7'h58: ret_reg<=pc+1, pc<=K, branch_taken=1.
  - RET 7'h59: pc<=ret_reg, branch_taken=1.
  - A nested CALL overwrites ret_reg.
  - For both, opcode output is NOP and issue=0.
- FETCH_SEQ_CALL_EN undefined:
  - 7'h58 and 7'h59 are ordinary pass-through opcodes: issue=1, pc+1.
  - No ret_reg is built.

## Structure
- Shared package isa_pkg: OP_W/K_W constants, NOP/HALT/jump/CALL/RET opcode localparams, status bit index constants, fetch state enum.
- One sub-module, branch_eval: combinational; inputs are opcode and status; outputs are is_flow and taken.

## Test plan
- Reset, then a program of MOV A,K(K=5) at 0 and ADD A,K(K=3) at 1, with zero-wait ack -> issue in cycles 3 and 5; opcodes 7'h02 then 7'h06; pc goes 0->1->2.
- JEQ K=8'h10 with status=4'b0001 -> branch_taken=1, pc=8'h10, issue=0, opcode=7'h7E. Repeat with status=4'b0000 -> pc=pc+1.
- Sequential execution from pc=8'hFF -> next imem_addr=8'h00.
- imem_ack delayed 3 cycles with rdata toggled before the ack -> imem_addr held constant, only the ack-cycle rdata is executed.
- rst_n=0 during REQ, with ack arriving the next cycle -> imem_req=0, the ack is ignored, state is IDLE and pc=0.
- HALT at pc=4 -> halted=1, no further imem_req. With FETCH_SEQ_CALL_EN: CALL K=8'h20 at pc=2, then RET -> pc goes 2 -> 8'h20, and after RET pc=3.
